serial_pattern_tx: RTL
======================

// Module: serial_pattern_tx
// PURPOSE
// - Transmit side of the serial bitstream link that feeds the Mealy sequence detectors.
// - Accepts parallel words over a valid/ready handshake and shifts each word out MSB-first, one bit per clk.
// - Marks each word with per-bit valid and start/end-of-word strobes.
// - Drives detector benches and on-chip stimulus; GAP=0 gives a gapless stream, so patterns spanning word boundaries are exercised.
// PARAMETERS
// - WIDTH       8  bits per word, >=2
// - GAP         1  idle cycles inserted after each word, 0..15; 0 = back-to-back streaming
// - IDLE_LEVEL  0  value driven on bitstream when no bit is being sent
// PORTS
// - clk         in   1      rising-edge clock, single clock domain
// - reset       in   1      synchronous, active-low reset (0 = reset, sampled on clk rising edge)
// - data_in     in   WIDTH  parallel word, bit WIDTH-1 sent first
// - data_valid  in   1      data_in valid; source holds word and valid until accepted
// - data_ready  out  1      block can accept a word this cycle
// - bitstream   out  1      serial data out, registered
// - bit_valid   out  1      bitstream carries a word (or parity) bit this cycle
// - sof         out  1      first bit of word on bitstream
// - eof         out  1      last bit of word on bitstream (parity bit when SERIAL_TX_PARITY_EN)
// - busy        out  1      state != IDLE
// BEHAVIOUR
// - Reset (reset==0 at rising edge): state=IDLE, shift reg=0, bit counter=0, gap counter=0.
// - Reset outputs: bitstream=IDLE_LEVEL, bit_valid=0, sof=0, eof=0, busy=0.
// - data_ready is forced 0 while reset is low.
// - Reset mid-word or mid-gap aborts immediately; the partial word is discarded, not resumed.
// - Accept: data_valid && data_ready at rising edge N -> data_in captured.
//   - Cycle N+1: bitstream = data_in[WIDTH-1], bit_valid=1, sof=1.
//   - Cycle N+WIDTH: bitstream = data_in[0], eof=1 (no parity build).
// - States:
//   - IDLE:   data_ready=1; on accept -> SHIFT.
//   - SHIFT:  WIDTH cycles, one bit per cycle, counter WIDTH-1 down to 0, bit_valid=1.
//     - Last bit, no parity: -> GAP if GAP>0; else -> SHIFT on accept, or -> IDLE.
//     - Last bit, parity enabled: -> PARITY.
//   - PARITY: present only with SERIAL_TX_PARITY_EN; one cycle; exit rules as the SHIFT last bit.
//   - GAP:    GAP cycles, bitstream=IDLE_LEVEL, bit_valid=0, data_ready=0; then -> IDLE.
// - Back-to-back (GAP==0): data_ready=1 also in the final bit cycle of a word.
//   - Accept there -> next word's MSB on the very next cycle, sof=1, no bubble.
// - data_ready=0 in all other SHIFT/PARITY cycles; data_valid there is ignored, nothing captured.
// - sof and eof both registered, both 1-cycle pulses, never asserted when bit_valid=0.
// - WIDTH==1 is illegal.
// - All outputs registered except data_ready (decoded from state, gated by reset).
// CONFIGURATION
// - SERIAL_TX_PARITY_EN defined:
//   - One even-parity bit (XOR of the word) follows bit 0: bit_valid=1, eof on the parity bit.
//   - Word occupies WIDTH+1 cycles.
// - Not defined: no PARITY state; word occupies WIDTH cycles; eof on bit 0.
// TESTING
// - WIDTH=8, GAP=1, send 8'h36 -> bitstream 0,0,1,1,0,1,1,0 in 8 consecutive cycles.
//   - sof on cycle 1, eof on cycle 8; then 1 idle cycle at IDLE_LEVEL; then data_ready=1.
// - GAP=0, data_valid held high with 8'h36 then 8'h6C -> 16 consecutive bit_valid cycles:
//   - bits 0011011001101100, sof at bits 1 and 9, no bubble between words.
// - GAP=2, two words -> exactly 2 cycles with bit_valid=0 and data_ready=0 between eof and next-word acceptance.
// - data_valid pulsed with 8'hFF during SHIFT of 8'h00 -> ignored.
//   - Stream stays 00000000; the held 8'hFF is accepted only once data_ready=1.
// - reset driven low at bit 4 of 8'hA5 -> next edge: bit_valid=0, bitstream=IDLE_LEVEL, busy=0.
//   - Release -> data_ready=1 and a fresh word transmits fully from its MSB.
// - SERIAL_TX_PARITY_EN:
//   - 8'hB4 -> 9 bits 1,0,1,1,0,1,0,0,0 (parity 0), eof on the 9th.
//   - 8'hB5 -> parity bit 1.

Source files
------------

// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: parallel word in over valid/ready, MSB-first
// bitstream out with per-bit valid, sof/eof strobes and optional gap.
//
// Ports:
//   clk        - rising-edge clock
//   reset      - synchronous active-low reset
//   data_in    - parallel word, bit WIDTH-1 sent first
//   data_valid - data_in valid, held by source until accepted
//   data_ready - word can be accepted this cycle (combinational)
//   bitstream  - serial data, IDLE_LEVEL when no bit is sent
//   bit_valid  - bitstream carries a word/parity bit
//   sof, eof   - first / last bit of the word
//   busy       - not idle
//
// Build option: define SERIAL_TX_PARITY_EN to append an even-parity
// bit after bit 0 (eof then marks the parity bit).
module serial_pattern_tx #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned GAP        = 1,
   parameter logic        IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             data_valid,
   output logic             data_ready,
   output logic             bitstream,
   output logic             bit_valid,
   output logic             sof,
   output logic             eof,
   output logic             busy
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LD = CW'(WIDTH - 1);
   localparam logic [3:0] GAP_LD =
      (GAP > 0) ? 4'(GAP - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_GAP
`ifdef SERIAL_TX_PARITY_EN
      , S_PARITY
`endif
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] shreg_q;
   logic [CW-1:0]    bitcnt_q;
   logic [3:0]       gapcnt_q;
   logic             bitstream_q;
   logic             bit_valid_q;
   logic             sof_q;
   logic             eof_q;
   logic             busy_q;
`ifdef SERIAL_TX_PARITY_EN
   logic             par_q;
`endif
   logic             accept;

   // Ready in IDLE, and also in the final bit cycle when
   // streaming back-to-back so the next MSB follows with no bubble.
   always_comb begin
      data_ready = 1'b0;
      if (reset) begin
         unique case (state_q)
            S_IDLE:   data_ready = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: data_ready = (GAP == 0);
`else
            S_SHIFT:  data_ready = (GAP == 0) &&
                                   (bitcnt_q == '0);
`endif
            default:  data_ready = 1'b0;
         endcase
      end
   end

   assign accept = data_valid && data_ready;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         shreg_q     <= '0;
         bitcnt_q    <= '0;
         gapcnt_q    <= '0;
         bitstream_q <= IDLE_LEVEL;
         bit_valid_q <= 1'b0;
         sof_q       <= 1'b0;
         eof_q       <= 1'b0;
         busy_q      <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
         par_q       <= 1'b0;
`endif
      end else if (accept) begin
         // MSB goes out now; the rest waits left-aligned.
         state_q     <= S_SHIFT;
         shreg_q     <= {data_in[WIDTH-2:0], 1'b0};
         bitcnt_q    <= CNT_LD;
         bitstream_q <= data_in[WIDTH-1];
         bit_valid_q <= 1'b1;
         sof_q       <= 1'b1;
         eof_q       <= 1'b0;
         busy_q      <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
         par_q       <= ^data_in;
`endif
      end else begin
         sof_q <= 1'b0;
         eof_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               bitstream_q <= IDLE_LEVEL;
               bit_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
            S_SHIFT: begin
               if (bitcnt_q != '0) begin
                  bitstream_q <= shreg_q[WIDTH-1];
                  shreg_q     <= {shreg_q[WIDTH-2:0], 1'b0};
                  bitcnt_q    <= bitcnt_q - CW'(1);
                  bit_valid_q <= 1'b1;
`ifndef SERIAL_TX_PARITY_EN
                  eof_q       <= (bitcnt_q == CW'(1));
`endif
               end else begin
`ifdef SERIAL_TX_PARITY_EN
                  state_q     <= S_PARITY;
                  bitstream_q <= par_q;
                  bit_valid_q <= 1'b1;
                  eof_q       <= 1'b1;
`else
                  bitstream_q <= IDLE_LEVEL;
                  bit_valid_q <= 1'b0;
                  if (GAP > 0) begin
                     state_q  <= S_GAP;
                     gapcnt_q <= GAP_LD;
                     busy_q   <= 1'b1;
                  end else begin
                     state_q  <= S_IDLE;
                     busy_q   <= 1'b0;
                  end
`endif
               end
            end
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: begin
               bitstream_q <= IDLE_LEVEL;
               bit_valid_q <= 1'b0;
               if (GAP > 0) begin
                  state_q  <= S_GAP;
                  gapcnt_q <= GAP_LD;
                  busy_q   <= 1'b1;
               end else begin
                  state_q  <= S_IDLE;
                  busy_q   <= 1'b0;
               end
            end
`endif
            S_GAP: begin
               bitstream_q <= IDLE_LEVEL;
               bit_valid_q <= 1'b0;
               if (gapcnt_q == 4'd0) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  gapcnt_q <= gapcnt_q - 4'd1;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               bitstream_q <= IDLE_LEVEL;
               bit_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bitstream = bitstream_q;
   assign bit_valid = bit_valid_q;
   assign sof       = sof_q;
   assign eof       = eof_q;
   assign busy      = busy_q;

endmodule
